// File: rtl/xbee_uart_tx.sv
// ============================================================================
//  Module   : xbee_uart_tx
//  Purpose  : FIFO-buffered UART (8N1) transmitter feeding an XBee DIN pin.
//             Define XBEE_PARITY_EN to insert an even-parity bit (8E1).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xbee_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ND,
   input  logic       Eviction,
   input  logic       Sent,
   input  logic [7:0] Din,
   output logic       BusyFlag,
   output logic       DoutTx
);

   localparam int              c_CW       = $clog2(CLKS_PER_BIT);
   localparam int              c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef XBEE_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [c_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [c_AW:0]   count_q, count_d;
   logic            busy_q;

   state_t          state_q;
   logic [c_CW-1:0] cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            parity_q;
   logic            dout_q;

   logic            w_push, w_pop, w_start, w_bit_end;

   assign w_push    = ND & ~busy_q & ~Eviction;
   assign w_bit_end = (cnt_q == c_CNT_LAST);
   assign w_start   = (count_q != '0) & Sent & ~Eviction;
   // Pop happens from IDLE or on the final STOP cycle so frames run back-to-back.
   assign w_pop     = w_start & ((state_q == IDLE) | ((state_q == STOP) & w_bit_end));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (Eviction) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (w_push && !w_pop)      count_d = count_q + 1'b1;
         else if (!w_push && w_pop) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         busy_q   <= (count_d == c_FULL);
      end
   end

   always_ff @(posedge Clk) begin
      if (w_push) mem_q[wr_ptr_q] <= Din;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         dout_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               dout_q <= 1'b1;
               if (w_pop) begin
                  shift_q  <= mem_q[rd_ptr_q];
                  parity_q <= ^mem_q[rd_ptr_q];
                  dout_q   <= 1'b0;
                  state_q  <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  dout_q  <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
`ifdef XBEE_PARITY_EN
                     dout_q  <= parity_q;
                     state_q <= PARITY;
`else
                     dout_q  <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= shift_q >> 1;
                     dout_q  <= shift_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef XBEE_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  cnt_q   <= '0;
                  dout_q  <= 1'b1;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_bit_end) begin
                  cnt_q <= '0;
                  if (w_pop) begin
                     shift_q  <= mem_q[rd_ptr_q];
                     parity_q <= ^mem_q[rd_ptr_q];
                     dout_q   <= 1'b0;
                     state_q  <= START;
                  end else begin
                     dout_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_q   <= '0;
               dout_q  <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign BusyFlag = busy_q;
   assign DoutTx   = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_xbee_uart_tx.sv
// ============================================================================
//  Module   : tb_xbee_uart_tx
//  Purpose  : Directed self-checking bench for xbee_uart_tx (CLKS_PER_BIT=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xbee_uart_tx;

   localparam int CPB = 4;
`ifdef XBEE_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       ND = 1'b0;
   logic       Eviction = 1'b0;
   logic       Sent = 1'b0;
   logic [7:0] Din = 8'h00;
   logic       BusyFlag;
   logic       DoutTx;

   int n_checks = 0;
   int n_errors = 0;

   xbee_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .ND       (ND),
      .Eviction (Eviction),
      .Sent     (Sent),
      .Din      (Din),
      .BusyFlag (BusyFlag),
      .DoutTx   (DoutTx)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_for(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         check(tag, DoutTx, 1);
         tick();
      end
   endtask

   // Starts on the first start-bit cycle; ends on the first cycle after the frame.
   task automatic expect_frame(input logic [7:0] b, input int evict_at);
      logic [10:0] bits;
`ifdef XBEE_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {1'b0, 1'b1, b, 1'b0};
`endif
      for (int i = 0; i < NBITS; i++) begin
         for (int k = 0; k < CPB; k++) begin
            Eviction = ((i * CPB + k) == evict_at);
            check($sformatf("frame_%02h_bit%0d", b, i), DoutTx, bits[i]);
            tick();
         end
      end
      Eviction = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_dout", DoutTx, 1);
      check("reset_busy", BusyFlag, 0);
      Reset = 1'b0;
      idle_for(20, "idle_after_reset");
      check("idle_busy", BusyFlag, 0);

      // Single byte, exact latency
      Sent = 1'b1;
      ND = 1'b1; Din = 8'hCE;
      tick();
      ND = 1'b0;
      check("latency_write_cycle", DoutTx, 1);
      tick();
      expect_frame(8'hCE, -1);
      idle_for(12, "idle_after_single");

      // Sent gating: three bytes held, then released back-to-back
      Sent = 1'b0;
      ND = 1'b1; Din = 8'h11; tick();
      Din = 8'h22; tick();
      Din = 8'h33; tick();
      ND = 1'b0;
      idle_for(20, "held_by_sent");
      Sent = 1'b1;
      tick();
      expect_frame(8'h11, -1);
      expect_frame(8'h22, -1);
      expect_frame(8'h33, -1);
      idle_for(12, "idle_after_three");

      // Fill to full, overflow write dropped, drain with pointer wrap
      Sent = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ND = 1'b1; Din = 8'h40 + 8'(i);
         check("fill_busy_low", BusyFlag, 0);
         tick();
      end
      check("full_busy", BusyFlag, 1);
      Din = 8'hFF; tick(); tick();
      ND = 1'b0;
      check("full_busy_hold", BusyFlag, 1);
      Sent = 1'b1;
      tick();
      check("pop_from_full_busy", BusyFlag, 0);
      for (int i = 0; i < 16; i++) expect_frame(8'h40 + 8'(i), -1);
      idle_for(12, "idle_after_drain");
      check("drained_busy", BusyFlag, 0);

      // ND held high: busy rises at 16 buffered, drops one cycle per pop
      ND = 1'b1; Din = 8'hCE;
      tick();
      check("hold_write", DoutTx, 1);
      tick();
      check("hold_start", DoutTx, 0);
      repeat (14) tick();
      check("hold_busy_15", BusyFlag, 0);
      tick();
      check("hold_busy_16", BusyFlag, 1);
      repeat (FRAME - 16) tick();
      check("hold_busy_end_frame", BusyFlag, 1);
      check("hold_stop_bit", DoutTx, 1);
      tick();
      check("hold_busy_dip", BusyFlag, 0);
      check("hold_no_gap", DoutTx, 0);
      tick();
      check("hold_busy_refill", BusyFlag, 1);
      ND = 1'b0;
      Eviction = 1'b1;
      tick();
      Eviction = 1'b0;
      check("evict_clears_busy", BusyFlag, 0);
      repeat (FRAME + 10) tick();
      idle_for(10, "idle_after_hold_evict");

      // Eviction mid-frame with 5 bytes queued
      Sent = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ND = 1'b1; Din = 8'hA0 + 8'(i);
         tick();
      end
      ND = 1'b0;
      Sent = 1'b1;
      tick();
      expect_frame(8'hA0, 20);
      check("evict_busy", BusyFlag, 0);
      idle_for(FRAME + 10, "no_frame_after_evict");

      // Reset mid-frame empties the FIFO
      Sent = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ND = 1'b1; Din = 8'h5A; tick();
      end
      ND = 1'b0;
      Sent = 1'b1;
      tick();
      check("pre_reset_start", DoutTx, 0);
      repeat (10) tick();
      Reset = 1'b1;
      tick();
      check("reset_mid_dout", DoutTx, 1);
      check("reset_mid_busy", BusyFlag, 0);
      Reset = 1'b0;
      idle_for(FRAME + 10, "idle_after_mid_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
